// File: rtl/v_pipe_query_mp.sv
// Multi-port list query pipeline: per-port request slots, round-robin arbitration onto one
// state-table read port, hazard replay against the update pipeline, and a coded per-port response.
package cfg_pkg;
  localparam int unsigned ENTRIES_N     = 4;
  localparam int unsigned ID_BITS       = 8;
  localparam int unsigned ADDR_BITS     = ID_BITS;
  localparam int unsigned LEVEL_BITS    = 2;
  localparam int unsigned KEY_BITS      = 16;
  localparam int unsigned VOLUME_BITS   = 16;
  localparam int unsigned LISTSIZE_BITS = 8;
endpackage

package v_pkg;
  typedef struct packed {
    logic [cfg_pkg::LISTSIZE_BITS-1:0]                           listsize;
    logic [cfg_pkg::ENTRIES_N-1:0][cfg_pkg::VOLUME_BITS-1:0]     volume;
    logic [cfg_pkg::ENTRIES_N-1:0][cfg_pkg::KEY_BITS-1:0]        key;
    logic [cfg_pkg::ENTRIES_N-1:0]                               vld;
  } state_t;
endpackage

module v_pipe_query_mp #(
  parameter int unsigned PORTS_N      = 2,
  parameter int unsigned UPD_STAGES_N = 5,
  parameter int unsigned RETRY_MAX    = 4,
  parameter int unsigned RAM_LAT      = 1,
  parameter int unsigned ENTRIES_N    = cfg_pkg::ENTRIES_N
) (
  input  logic                                          clk,
  input  logic                                          arst_n,
  input  logic [PORTS_N-1:0]                            i_lut_vld,
  output logic [PORTS_N-1:0]                            o_lut_rdy,
  input  logic [PORTS_N*cfg_pkg::ID_BITS-1:0]           i_lut_prod_id,
  input  logic [PORTS_N*cfg_pkg::LEVEL_BITS-1:0]        i_lut_level,
  output logic [PORTS_N-1:0]                            o_lut_vld_r,
  output logic [PORTS_N*cfg_pkg::KEY_BITS-1:0]          o_lut_key,
  output logic [PORTS_N*cfg_pkg::VOLUME_BITS-1:0]       o_lut_size,
  output logic [PORTS_N*cfg_pkg::LISTSIZE_BITS-1:0]     o_lut_listsize,
  output logic [PORTS_N*2-1:0]                          o_lut_error,
  output logic                                          o_state_ren,
  output logic [cfg_pkg::ADDR_BITS-1:0]                 o_state_raddr,
  input  v_pkg::state_t                                 i_state_rdata,
  input  logic [UPD_STAGES_N-1:0]                       i_upd_vld_r,
  input  logic [UPD_STAGES_N*cfg_pkg::ID_BITS-1:0]      i_upd_prod_id_r
);
  localparam int unsigned ID_BITS       = cfg_pkg::ID_BITS;
  localparam int unsigned LEVEL_BITS    = cfg_pkg::LEVEL_BITS;
  localparam int unsigned KEY_BITS      = cfg_pkg::KEY_BITS;
  localparam int unsigned VOLUME_BITS   = cfg_pkg::VOLUME_BITS;
  localparam int unsigned LISTSIZE_BITS = cfg_pkg::LISTSIZE_BITS;
  localparam int unsigned CNT_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int unsigned PORT_W = (PORTS_N > 1) ? $clog2(PORTS_N) : 1;

  typedef struct packed {
    logic                 vld;
    logic                 rd;
    logic [PORT_W-1:0]    port;
    logic [ENTRIES_N-1:0] lvl;
    logic [ID_BITS-1:0]   id;
  } rsp_t;

  logic [PORTS_N-1:0]                  slot_vld_q, slot_vld_d;
  logic [PORTS_N-1:0][ID_BITS-1:0]     slot_id_q, slot_id_d;
  logic [PORTS_N-1:0][ENTRIES_N-1:0]   slot_lvl_q, slot_lvl_d;
  logic [PORTS_N-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [PORT_W-1:0]                   rr_q, rr_d;
  rsp_t [RAM_LAT-1:0]                  pipe_q, pipe_d;

  logic [PORTS_N-1:0]                  hazard, elig, grant, rdy;
  logic [PORTS_N-1:0][ENTRIES_N-1:0]   lvl_dec;
  logic                                gnt_vld, gnt_clean;
  logic [PORT_W-1:0]                   gnt_idx;
  rsp_t                                head;
  logic [KEY_BITS-1:0]                 key_sel;
  logic [VOLUME_BITS-1:0]              vol_sel;
  logic                                late_hz, rsp_busy, rsp_inval;
  logic [1:0]                          rsp_err;

  // Hazard compares the live update-stage flops every cycle, so a blocked slot frees as soon as the ID drains.
  always_comb begin
    hazard = '0;
    elig   = '0;
    for (int unsigned p = 0; p < PORTS_N; p++) begin
      for (int unsigned s = 0; s < UPD_STAGES_N; s++) begin
        if (i_upd_vld_r[s] && (i_upd_prod_id_r[s*ID_BITS +: ID_BITS] == slot_id_q[p])) begin
          hazard[p] = 1'b1;
        end
      end
      elig[p] = slot_vld_q[p] & (~hazard[p] | (cnt_q[p] == CNT_W'(RETRY_MAX)));
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int unsigned k = 0; k < PORTS_N; k++) begin
      int unsigned idx;
      idx = (32'(rr_q) + k) % PORTS_N;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PORT_W'(idx);
      end
    end
    grant[gnt_idx] = gnt_vld;
    gnt_clean      = gnt_vld & ~hazard[gnt_idx];
    rdy            = ~slot_vld_q | grant;
  end

  assign o_lut_rdy     = rdy;
  assign o_state_ren   = gnt_clean;
  assign o_state_raddr = gnt_clean ? slot_id_q[gnt_idx] : '0;

  always_comb begin
    lvl_dec = '0;
    for (int unsigned p = 0; p < PORTS_N; p++) begin
      for (int unsigned e = 0; e < ENTRIES_N; e++) begin
        if (i_lut_level[p*LEVEL_BITS +: LEVEL_BITS] == LEVEL_BITS'(e)) begin
          lvl_dec[p][e] = 1'b1;
        end
      end
    end
  end

  // A granted slot frees and may reload from a same-cycle transfer on its port.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_id_d  = slot_id_q;
    slot_lvl_d = slot_lvl_q;
    cnt_d      = cnt_q;
    for (int unsigned p = 0; p < PORTS_N; p++) begin
      if (grant[p]) begin
        slot_vld_d[p] = 1'b0;
      end else if (slot_vld_q[p] && hazard[p] && (cnt_q[p] != CNT_W'(RETRY_MAX))) begin
        cnt_d[p] = cnt_q[p] + CNT_W'(1);
      end
      if (i_lut_vld[p] && rdy[p]) begin
        slot_vld_d[p] = 1'b1;
        slot_id_d[p]  = i_lut_prod_id[p*ID_BITS +: ID_BITS];
        slot_lvl_d[p] = lvl_dec[p];
        cnt_d[p]      = '0;
      end
    end
    rr_d = gnt_vld ? PORT_W'((32'(gnt_idx) + 1) % PORTS_N) : rr_q;
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = '0;
    if (gnt_vld) begin
      pipe_d[0].vld  = 1'b1;
      pipe_d[0].rd   = gnt_clean;
      pipe_d[0].port = gnt_idx;
      pipe_d[0].lvl  = slot_lvl_q[gnt_idx];
      pipe_d[0].id   = slot_id_q[gnt_idx];
    end
    for (int unsigned i = 1; i < RAM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      slot_vld_q <= '0;
      slot_id_q  <= '0;
      slot_lvl_q <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      pipe_q     <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_id_q  <= slot_id_d;
      slot_lvl_q <= slot_lvl_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      pipe_q     <= pipe_d;
    end
  end

  // The pipe head lines up with read data arriving RAM_LAT cycles after the grant.
  always_comb begin
    head      = pipe_q[RAM_LAT-1];
    key_sel   = '0;
    vol_sel   = '0;
    for (int unsigned e = 0; e < ENTRIES_N; e++) begin
      if (head.lvl[e]) begin
        key_sel = key_sel | i_state_rdata.key[e];
        vol_sel = vol_sel | i_state_rdata.volume[e];
      end
    end
    late_hz   = i_upd_vld_r[0] && (i_upd_prod_id_r[ID_BITS-1:0] == head.id);
    rsp_busy  = ~head.rd | late_hz;
    rsp_inval = (head.lvl & i_state_rdata.vld) == '0;
    rsp_err   = rsp_busy ? 2'b01 : (rsp_inval ? 2'b10 : 2'b00);

    o_lut_vld_r    = '0;
    o_lut_key      = '0;
    o_lut_size     = '0;
    o_lut_listsize = '0;
    o_lut_error    = '0;
    for (int unsigned p = 0; p < PORTS_N; p++) begin
      if (head.vld && (head.port == PORT_W'(p))) begin
        o_lut_vld_r[p]         = 1'b1;
        o_lut_error[p*2 +: 2]  = rsp_err;
        if (head.rd) begin
          o_lut_key[p*KEY_BITS +: KEY_BITS]                = key_sel;
          o_lut_size[p*VOLUME_BITS +: VOLUME_BITS]         = vol_sel;
          o_lut_listsize[p*LISTSIZE_BITS +: LISTSIZE_BITS] = i_state_rdata.listsize;
        end
      end
    end
  end
endmodule

// File: tb/tb_v_pipe_query_mp.sv
// Bench for v_pipe_query_mp: directed scenarios plus random traffic, checked every cycle
// against a request-level reference model of slots, arbitration and expected responses.
module tb_v_pipe_query_mp;
  localparam int unsigned P   = 2;
  localparam int unsigned S   = 5;
  localparam int unsigned RM  = 4;
  localparam int unsigned IDB = cfg_pkg::ID_BITS;
  localparam int unsigned LB  = cfg_pkg::LEVEL_BITS;
  localparam int unsigned KB  = cfg_pkg::KEY_BITS;
  localparam int unsigned VB  = cfg_pkg::VOLUME_BITS;
  localparam int unsigned LSB = cfg_pkg::LISTSIZE_BITS;
  localparam int unsigned E   = cfg_pkg::ENTRIES_N;

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic [P-1:0]         vld = '0;
  logic [P-1:0]         rdy;
  logic [P*IDB-1:0]     pid = '0;
  logic [P*LB-1:0]      lvl = '0;
  logic [P-1:0]         vld_r;
  logic [P*KB-1:0]      key;
  logic [P*VB-1:0]      size;
  logic [P*LSB-1:0]     lsize;
  logic [P*2-1:0]       err;
  logic                 ren;
  logic [IDB-1:0]       raddr;
  v_pkg::state_t        rdata = '0;
  logic [S-1:0]         uv = '0;
  logic [S*IDB-1:0]     uid = '0;

  always #5 clk = ~clk;

  v_pipe_query_mp #(.PORTS_N(P), .UPD_STAGES_N(S), .RETRY_MAX(RM), .RAM_LAT(1)) dut (
    .clk(clk), .arst_n(arst_n),
    .i_lut_vld(vld), .o_lut_rdy(rdy), .i_lut_prod_id(pid), .i_lut_level(lvl),
    .o_lut_vld_r(vld_r), .o_lut_key(key), .o_lut_size(size), .o_lut_listsize(lsize),
    .o_lut_error(err), .o_state_ren(ren), .o_state_raddr(raddr), .i_state_rdata(rdata),
    .i_upd_vld_r(uv), .i_upd_prod_id_r(uid)
  );

  v_pkg::state_t mem [256];
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  typedef struct { int unsigned port; int unsigned lv; int unsigned id; bit rd; int due; } pend_t;
  pend_t       pq[$];
  bit          m_busy [P];
  int unsigned m_id [P];
  int unsigned m_lv [P];
  int unsigned m_cnt [P];
  int unsigned m_rr;
  int          cyc;
  int          nvec = 0;
  int          nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    for (int p = 0; p < P; p++) begin m_busy[p] = 0; m_id[p] = 0; m_lv[p] = 0; m_cnt[p] = 0; end
    m_rr = 0;
  endtask

  // One clock: compare the DUT against the model at the negedge, then advance the model at the posedge.
  task automatic cycle();
    bit hz [P];
    bit el [P];
    int g;
    logic [P-1:0]     e_rdy;
    logic [P-1:0]     e_vr;
    logic [P*KB-1:0]  e_key;
    logic [P*VB-1:0]  e_sz;
    logic [P*LSB-1:0] e_ls;
    logic [P*2-1:0]   e_err;
    bit               e_ren;
    bit               resp;
    v_pkg::state_t    st;
    bit               busy;
    @(negedge clk);
    g = -1;
    for (int p = 0; p < P; p++) begin
      hz[p] = 0;
      if (m_busy[p])
        for (int s = 0; s < S; s++)
          if (uv[s] && uid[s*IDB +: IDB] == IDB'(m_id[p])) hz[p] = 1;
      el[p] = m_busy[p] && (!hz[p] || m_cnt[p] == RM);
    end
    for (int k = 0; k < P; k++) begin
      int q;
      q = int'((m_rr + k) % P);
      if (g < 0 && el[q]) g = q;
    end
    for (int p = 0; p < P; p++) e_rdy[p] = !m_busy[p] || g == p;
    e_ren = (g >= 0) && !hz[g];
    e_vr = '0; e_key = '0; e_sz = '0; e_ls = '0; e_err = '0;
    resp = pq.size() > 0 && pq[0].due == cyc;
    if (resp) begin
      st = mem[pq[0].id];
      busy = !pq[0].rd || (uv[0] && uid[IDB-1:0] == IDB'(pq[0].id));
      e_vr[pq[0].port] = 1'b1;
      e_err[pq[0].port*2 +: 2] = busy ? 2'd1 : (st.vld[pq[0].lv] ? 2'd0 : 2'd2);
      if (pq[0].rd) begin
        e_key[pq[0].port*KB +: KB]  = st.key[pq[0].lv];
        e_sz[pq[0].port*VB +: VB]   = st.volume[pq[0].lv];
        e_ls[pq[0].port*LSB +: LSB] = st.listsize;
      end
    end
    chk("rdy", 64'(rdy), 64'(e_rdy));
    chk("ren", 64'(ren), 64'(e_ren));
    if (e_ren) chk("raddr", 64'(raddr), 64'(m_id[g]));
    chk("vld_r", 64'(vld_r), 64'(e_vr));
    chk("error", 64'(err), 64'(e_err));
    chk("key", 64'(key), 64'(e_key));
    chk("volume", 64'(size), 64'(e_sz));
    chk("listsize", 64'(lsize), 64'(e_ls));
    @(posedge clk);
    if (resp) void'(pq.pop_front());
    if (g >= 0) begin
      pq.push_back('{port: g, lv: m_lv[g], id: m_id[g], rd: !hz[g], due: cyc + 1});
      m_busy[g] = 0;
      m_rr = (g + 1) % P;
    end
    for (int p = 0; p < P; p++)
      if (p != g && m_busy[p] && hz[p] && m_cnt[p] < RM) m_cnt[p]++;
    for (int p = 0; p < P; p++)
      if (vld[p] && e_rdy[p]) begin
        m_busy[p] = 1; m_id[p] = pid[p*IDB +: IDB]; m_lv[p] = lvl[p*LB +: LB]; m_cnt[p] = 0;
      end
    cyc++;
    #1;
  endtask

  task automatic req(input int p, input int unsigned id, input int unsigned lv);
    vld[p] = 1'b1; pid[p*IDB +: IDB] = IDB'(id); lvl[p*LB +: LB] = LB'(lv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      for (int e = 0; e < E; e++) begin
        mem[i].key[e]    = KB'($urandom);
        mem[i].volume[e] = VB'($urandom);
      end
      mem[i].vld      = E'($urandom);
      mem[i].listsize = LSB'($urandom);
    end
    mem[3].vld = 4'b0010;

    #12;
    chk("rst_vld_r", 64'(vld_r), 64'd0);
    chk("rst_ren", 64'(ren), 64'd0);
    chk("rst_error", 64'(err), 64'd0);
    chk("rst_key", 64'(key), 64'd0);
    chk("rst_rdy", 64'(rdy), 64'(3));
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Single clean query, then the same query against an entry whose level is not valid.
    req(0, 3, 1); cycle(); vld = '0; idle(3);
    mem[3].vld = 4'b0001;
    req(0, 3, 1); cycle(); vld = '0; idle(3);

    // Persistent hazard: slot replays up to RM cycles, then a BUSY response with no read.
    uv[2] = 1'b1; uid[2*IDB +: IDB] = 8'd5;
    req(0, 5, 2); cycle(); vld = '0; idle(9);
    uv = '0; idle(2);

    // Hazard clearing after two cycles, then a follow-up request starts with a fresh counter.
    uv[4] = 1'b1; uid[4*IDB +: IDB] = 8'd6;
    req(1, 6, 0); cycle(); vld = '0; idle(2);
    uv = '0; idle(3);
    req(1, 6, 3); cycle(); vld = '0; idle(3);

    // Both ports streaming: grants alternate.
    req(0, 1, 0); req(1, 2, 3);
    idle(10);
    vld = '0; idle(3);

    // Late hazard at response time on update stage S1.
    req(0, 7, 1); cycle(); vld = '0; cycle();
    uv[0] = 1'b1; uid[IDB-1:0] = 8'd7; cycle(); uv = '0; idle(2);

    // Reset while a read is in flight discards it.
    req(0, 4, 2); cycle(); vld = '0; cycle();
    arst_n = 1'b0; #1;
    model_reset();
    @(negedge clk);
    chk("rst_mid_vld_r", 64'(vld_r), 64'd0);
    chk("rst_mid_rdy", 64'(rdy), 64'(3));
    arst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);

    // Random traffic with frequent ID collisions.
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < P; p++) begin
        vld[p] = ($urandom_range(0, 2) != 0);
        pid[p*IDB +: IDB] = IDB'($urandom_range(0, 7));
        lvl[p*LB +: LB]   = LB'($urandom_range(0, E - 1));
      end
      for (int s = 0; s < S; s++) begin
        uv[s] = ($urandom_range(0, 7) == 0);
        uid[s*IDB +: IDB] = IDB'($urandom_range(0, 7));
      end
      cycle();
    end
    vld = '0; uv = '0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/v_pipe_query_mp.md
Name: v_pipe_query_mp

Overview:
- Multi-port successor to the single-port list query pipeline.
- Accepts up to PORTS_N concurrent list queries (prod_id, level) and arbitrates them round-robin onto the single state-table read port.
- Returns key, volume, listsize and a coded error per port.
- Conflicts with in-flight updates are replayed for up to RETRY_MAX cycles before erroring out, where the predecessor errored out immediately; update-pipeline depth and RAM read latency are parameters.

Parameters:
PORTS_N, 2, number of independent query ports (1..8)
UPD_STAGES_N, 5, number of update-pipeline stages checked for ID hazards
RETRY_MAX, 4, blocked cycles tolerated before a BUSY error; 0 gives immediate error (legacy behaviour)
RAM_LAT, 1, state-table read latency in cycles (1 or 2)
ENTRIES_N, cfg_pkg::ENTRIES_N, levels per state-table entry

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
i_lut_vld  in  PORTS_N  per-port query request
o_lut_rdy  out  PORTS_N  per-port accept; transfer when vld&rdy
i_lut_prod_id  in  PORTS_N*ID_BITS  per-port product ID
i_lut_level  in  PORTS_N*LEVEL_BITS  per-port level
o_lut_vld_r  out  PORTS_N  per-port response strobe, one cycle
o_lut_key  out  PORTS_N*KEY_BITS  response key
o_lut_size  out  PORTS_N*VOLUME_BITS  response volume
o_lut_listsize  out  PORTS_N*LISTSIZE_BITS  response list occupancy
o_lut_error  out  PORTS_N*2  00 OK, 01 BUSY, 10 INVALID
o_state_ren  out  1  state-table read enable
o_state_raddr  out  ADDR_BITS  state-table read address (= prod_id)
i_state_rdata  in  v_pkg::state_t  read data, RAM_LAT cycles after ren
i_upd_vld_r  in  UPD_STAGES_N  update stage valid, index 0 = S1
i_upd_prod_id_r  in  UPD_STAGES_N*ID_BITS  update stage product ID

Behaviour:
- Reset (arst_n low, async):
  - All slots empty; retry counters 0; RR pointer 0; response pipe empty.
  - o_lut_vld_r=0, o_state_ren=0, o_lut_error=0, data outputs 0.
- Per-port request slot (one entry):
  - o_lut_rdy[p] = ~slot_vld[p] | grant[p].
  - On transfer, capture prod_id; decode level to one-hot ENTRIES_N; clear the retry counter.
- Hazard[p]: slot ID equals any i_upd_prod_id_r[s] with i_upd_vld_r[s] set, checked every cycle against live stage flops.
- Eligibility: slot valid and (~hazard or retry_cnt==RETRY_MAX).
- Blocked slot (valid, hazard, cnt<RETRY_MAX): cnt increments each cycle it is not granted; cnt saturates.
- Arbiter:
  - Round-robin over eligible slots, one grant per cycle, starting search at last granted+1 mod PORTS_N.
  - RR pointer updates only on a grant.
- Grant of a clean slot:
  - o_state_ren=1, raddr=prod_id in the same cycle.
  - Push {port, level_dec, prod_id, rd=1} into a RAM_LAT-deep response shift pipe.
  - Slot frees.
- Grant of an exhausted slot: no ren; push with rd=0 and forced BUSY; slot frees.
- Response cycle (pipe head valid):
  - Assert o_lut_vld_r[port] only.
  - key and volume muxed by level_dec from i_state_rdata; listsize = i_state_rdata.listsize.
  - If rd=0: data outputs 0, error BUSY.
- Late hazard at response: if i_upd_vld_r[0] and i_upd_prod_id_r[0] == head prod_id, error BUSY.
- Invalid entry: (level_dec & i_state_rdata.vld)==0 gives INVALID.
- Error precedence: BUSY over INVALID.
- Timing:
  - Total latency accept→response = 1 + RAM_LAT cycles minimum (unblocked, uncontended).
  - Aggregate throughput: one response per cycle.
- Non-responding ports' data outputs are don't-care but driven 0.
- RETRY_MAX=0: a hazard slot is immediately eligible with BUSY.
- Simultaneous accept and grant on the same port: the new request loads the slot freed that cycle.
- Reset mid-operation: in-flight reads are discarded; no response is issued for them.

Test Plan:
- Single query, port0 id=3 level=1, no updates, RAM vld=0b0010 → port0 response at cycle 2, error 00, key/volume from entry 1.
- Same query with RAM vld=0b0001 → error 10, response strobe still asserted once.
- Port0 id=5 with i_upd_vld_r[2] id=5 held for 10 cycles, RETRY_MAX=4 → no ren; BUSY response after 4 blocked cycles plus grant, no RAM read.
- Hazard clears after 2 cycles → ren issued on cycle 3 and OK response; counter reset for the next request.
- Both ports request every cycle, no hazards → grants alternate 0,1,0,1; each port gets one response per 2 cycles; aggregate 1 per cycle.
- arst_n pulsed while a read is in flight → no o_lut_vld_r afterwards, o_lut_rdy all 1 next cycle.
